// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB pipeline outputs in, decode read ports out.
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      wb_instr;
  logic [31:0]      wb_pc;
  logic [4:0]       wb_regaddr;
  logic [31:0]      wb_dmout;
  logic [31:0]      wb_alures;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             wb_we;
  logic [31:0]      wb_wdata;
  logic [CNT_W-1:0] retired;

  modport master (
    output wb_instr, wb_pc, wb_regaddr, wb_dmout, wb_alures, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_we, wb_wdata, retired
  );

  modport slave (
    input  wb_instr, wb_pc, wb_regaddr, wb_dmout, wb_alures, rs_addr, rt_addr,
    output rs_data, rt_data, wb_we, wb_wdata, retired
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects/format the commit value, owns the 32x32 GRF with
// same-cycle write-through bypass on both read ports, and counts retirements.
module wb_regfile #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int          CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      wdata;
  logic             we;
  logic [31:0]      regs [32];
  logic [CNT_W-1:0] cnt;

  assign op    = bus.wb_instr[31:26];
  assign funct = bus.wb_instr[5:0];

  // Byte/halfword lane extraction from the load address low bits.
  always_comb begin
    ld_byte = bus.wb_dmout[7:0];
    case (bus.wb_alures[1:0])
      2'b00: ld_byte = bus.wb_dmout[7:0];
      2'b01: ld_byte = bus.wb_dmout[15:8];
      2'b10: ld_byte = bus.wb_dmout[23:16];
      2'b11: ld_byte = bus.wb_dmout[31:24];
      default: ld_byte = bus.wb_dmout[7:0];
    endcase
    ld_half = bus.wb_alures[1] ? bus.wb_dmout[31:16] : bus.wb_dmout[15:0];
  end

  // Write-back value select; upstream already gated wb_regaddr for non-writers.
  always_comb begin
    wdata = bus.wb_alures;
    case (op)
      OP_LW:    wdata = bus.wb_dmout;
      OP_LB:    wdata = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:   wdata = {24'h0, ld_byte};
      OP_LH:    wdata = {{16{ld_half[15]}}, ld_half};
      OP_LHU:   wdata = {16'h0, ld_half};
      OP_JAL:   wdata = bus.wb_pc + LINK_OFFSET;
      OP_RTYPE: if (funct == FN_JALR) wdata = bus.wb_pc + LINK_OFFSET;
      default:  wdata = bus.wb_alures;
    endcase
  end

  assign we           = (bus.wb_regaddr != 5'd0);
  assign bus.wb_we    = we;
  assign bus.wb_wdata = wdata;

  // Register array; reg 0 is never written because we is low for address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we) begin
      regs[bus.wb_regaddr] <= wdata;
    end
  end

  // Read ports with same-cycle bypass of the committing value.
  always_comb begin
    if (bus.rs_addr == 5'd0)                         bus.rs_data = 32'h0;
    else if (we && (bus.rs_addr == bus.wb_regaddr))  bus.rs_data = wdata;
    else                                             bus.rs_data = regs[bus.rs_addr];
    if (bus.rt_addr == 5'd0)                         bus.rt_data = 32'h0;
    else if (we && (bus.rt_addr == bus.wb_regaddr))  bus.rt_data = wdata;
    else                                             bus.rt_data = regs[bus.rt_addr];
  end

  // Retired counter: every non-bubble instruction, writer or not; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                      cnt <= '0;
    else if (bus.wb_instr != 32'h0) cnt <= cnt + 1'b1;
  end

  assign bus.retired = cnt;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus general register file (GRF). It consumes the outputs of the MEM/WB pipeline register.
- Selects and formats the write-back value: ALU result, extended load data, or link address.
- Commits that value into a 32x32 register file, which serves the decode-stage read ports with internal write-through bypass.
- Keeps a retired-instruction counter for bench/debug comparison against the reference simulator.

Parameters:
- LINK_OFFSET, 8, byte offset added to wb_pc for jal/jalr link value.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- wb_instr  input  32  instruction in WB; 32'h0 = bubble.
- wb_pc  input  32  PC of instruction in WB.
- wb_regaddr  input  5  destination register; upstream drives 0 for non-writing instructions.
- wb_dmout  input  32  raw word read from data memory.
- wb_alures  input  32  ALU result; also the load address.
- rs_addr  input  5  read port 1 address (decode stage).
- rt_addr  input  5  read port 2 address (decode stage).
- rs_data  output  32  read port 1 data, combinational.
- rt_data  output  32  read port 2 data, combinational.
- wb_we  output  1  register write strobe this cycle, combinational.
- wb_wdata  output  32  value written this cycle, combinational.
- retired  output  CNT_W  count of non-bubble instructions committed.

Behaviour:
- Reset: synchronous, active-high, clock clk. On reset, all 32 registers are cleared to 0 and retired is cleared to 0. Combinational outputs follow their inputs. With the pipeline register also reset, its outputs are all 0, so wb_we=0 and wb_wdata=0.
- Decode uses op=wb_instr[31:26] and funct=wb_instr[5:0].
- Write-data select:
  - lw (100011): wb_dmout.
  - lb (100000) / lbu (100100): byte selected by wb_alures[1:0] (00 = bits 7:0 … 11 = bits 31:24), sign- or zero-extended to 32.
  - lh (100001) / lhu (100101): halfword selected by wb_alures[1], bit 0 ignored, sign- or zero-extended.
  - jal (000011), or jalr (op 000000, funct 001001): wb_pc + LINK_OFFSET, mod 2^32.
  - All others: wb_alures.
- wb_we = (wb_regaddr != 0). No opcode qualification: upstream owns that.
- Write:
  - At posedge with wb_we=1 and reset=0, reg[wb_regaddr] <= wb_wdata.
  - reg[0] is never written and always reads 0.
- Read:
  - rs_data = 0 if rs_addr==0.
  - Else wb_wdata if wb_we and rs_addr==wb_regaddr (same-cycle bypass: a write and a read of the same register in one cycle returns the new value).
  - Else reg[rs_addr].
  - rt_data is identical using rt_addr.
- Latency: a write is visible combinationally in the same cycle via bypass, and from the array from the next cycle onward.
- retired increments by 1 at each posedge where reset=0 and wb_instr != 0, regardless of wb_we. It wraps at 2^CNT_W - 1 to 0.
- Reset while a write is pending: reset wins. The array stays all 0 and the counter stays 0.
- Writes to register 0 are dropped silently.
- Stores, branches and other non-writers still count as retired.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read 0, retired=0.
- instr=0x3C011234 (lui $1), regaddr=1, alures=0x12340000; next cycle read rs=1 -> 0x12340000; retired=1.
- lb with regaddr=2, dmout=0x80FF7F01, alures=...02 -> wdata=0xFFFFFFFF. Same with alures=...03 -> 0xFFFFFF80. lbu at ...03 -> 0x00000080. lh at ...02 -> 0xFFFF80FF. lhu at ...00 -> 0x00007F01.
- jal with pc=0x00003000, regaddr=31 -> reg31=0x00003008. jalr with pc=0x0000300C, regaddr=5 -> reg5=0x00003014.
- Write reg 7 = 0xDEADBEEF while rs_addr=rt_addr=7 in the same cycle -> both ports show 0xDEADBEEF before the edge. Then regaddr=0 with alures=0x5 -> wb_we=0, rs=0 reads 0.
- Assert reset in the same cycle as a write to reg 3 = 0x1 -> reg3 reads 0 after the edge, retired=0. A bubble (instr 0) does not advance retired.
